// File: rtl/coefficient_load_controller.sv
// coefficient_load_controller
// Streams a signed coefficient set from a synchronous store (1-cycle read
// latency) into the FIR coefficient shift register, one value per clock.
// It gates the filter's sample path while a load is running and pulses
// filterSetFlag once the full set has been shifted in.
module coefficient_load_controller #(
    parameter int LENGTH     = 20,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         loadRequest,
    output logic [ADDR_WIDTH-1:0]        coeffReadAddress,
    input  logic signed [DATA_WIDTH-1:0] coeffReadData,
    output logic signed [DATA_WIDTH-1:0] coefficientOut,
    output logic                         coefficientValid,
    output logic                         filterBusy,
    output logic                         filterSetFlag,
    output logic                         dataEnable
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE,
        RUN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LENGTH - 1);

    state_t state;
    logic   drain_count;   // counts the two flush cycles after the last address
    logic   fetch_d1;      // fetch-in-progress, aligned with store read data

    // Load sequencer: walks the store addresses and drives the registered
    // status outputs from the state being entered.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state            <= IDLE;
            coeffReadAddress <= '0;
            drain_count      <= 1'b0;
            filterBusy       <= 1'b0;
            filterSetFlag    <= 1'b0;
            dataEnable       <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // branch sees the pre-edge values, independent of statement order.
            filterSetFlag <= 1'b0;
            case (state)
                IDLE: begin
                    dataEnable <= 1'b0;
                    if (loadRequest) begin
                        state            <= FETCH;
                        coeffReadAddress <= '0;
                        filterBusy       <= 1'b1;
                    end
                end
                FETCH: begin
                    // Stop on the last address so the counter never wraps.
                    if (coeffReadAddress == LAST_ADDR) begin
                        state            <= DRAIN;
                        coeffReadAddress <= '0;
                        drain_count      <= 1'b0;
                    end else begin
                        coeffReadAddress <= coeffReadAddress + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    // Two cycles: one for the store latency, one for the output register.
                    if (drain_count) begin
                        state         <= DONE;
                        filterBusy    <= 1'b0;
                        filterSetFlag <= 1'b1;
                        dataEnable    <= 1'b1;
                    end else begin
                        drain_count <= 1'b1;
                    end
                end
                DONE: begin
                    state <= RUN;
                end
                RUN: begin
                    // Requests arriving mid-load are dropped; only IDLE/RUN listen.
                    if (loadRequest) begin
                        state            <= FETCH;
                        coeffReadAddress <= '0;
                        filterBusy       <= 1'b1;
                        dataEnable       <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output pipeline: delays the fetch marker by two cycles to line up with
    // the registered store data, and holds the last coefficient between loads.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            fetch_d1         <= 1'b0;
            coefficientValid <= 1'b0;
            coefficientOut   <= '0;
        end else begin
            fetch_d1         <= (state == FETCH);
            coefficientValid <= fetch_d1;
            if (fetch_d1) begin
                coefficientOut <= coeffReadData;
            end
        end
    end

endmodule

// File: tb/tb_coefficient_load_controller.sv
// Directed bench for coefficient_load_controller: a 20-tap instance driven
// from a per-cycle vector table, plus hand sequences for reloads, reset
// mid-load, and the LENGTH=1 / LENGTH=16 corner instances.
module tb_coefficient_load_controller;

    logic clock  = 1'b0;
    logic resetN = 1'b1;
    logic req20  = 1'b0;
    logic req1   = 1'b0;
    logic req16  = 1'b0;

    always #5 clock = ~clock;

    // 20-tap instance
    logic [4:0]        addr20;
    logic signed [7:0] rdata20, out20;
    logic              valid20, busy20, flag20, en20;
    // 1-tap instance
    logic [0:0]        addr1;
    logic signed [7:0] rdata1, out1;
    logic              valid1, busy1, flag1, en1;
    // 16-tap instance
    logic [3:0]        addr16;
    logic signed [7:0] rdata16, out16;
    logic              valid16, busy16, flag16, en16;

    logic signed [7:0] store20 [20];
    logic signed [7:0] store1  [2];
    logic signed [7:0] store16 [16];

    int coeffs20 [20] = '{34, 34, 0, 49, 125, -77, -51, 8, 97, 109,
                          -91, -3, 9, 1, 59, 75, 19, 58, -97, 10};

    coefficient_load_controller #(.LENGTH(20), .DATA_WIDTH(8)) dut20 (
        .clock(clock), .resetN(resetN), .loadRequest(req20),
        .coeffReadAddress(addr20), .coeffReadData(rdata20),
        .coefficientOut(out20), .coefficientValid(valid20),
        .filterBusy(busy20), .filterSetFlag(flag20), .dataEnable(en20)
    );

    coefficient_load_controller #(.LENGTH(1), .DATA_WIDTH(8)) dut1 (
        .clock(clock), .resetN(resetN), .loadRequest(req1),
        .coeffReadAddress(addr1), .coeffReadData(rdata1),
        .coefficientOut(out1), .coefficientValid(valid1),
        .filterBusy(busy1), .filterSetFlag(flag1), .dataEnable(en1)
    );

    coefficient_load_controller #(.LENGTH(16), .DATA_WIDTH(8)) dut16 (
        .clock(clock), .resetN(resetN), .loadRequest(req16),
        .coeffReadAddress(addr16), .coeffReadData(rdata16),
        .coefficientOut(out16), .coefficientValid(valid16),
        .filterBusy(busy16), .filterSetFlag(flag16), .dataEnable(en16)
    );

    // Synchronous coefficient stores with one cycle of read latency
    always @(posedge clock) begin
        rdata20 <= store20[addr20];
        rdata1  <= store1[addr1];
        rdata16 <= store16[addr16];
    end

    int total = 0;
    int bad   = 0;
    int vcount;
    int fcount;
    int ph;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic              req;
        logic              valid;
        logic signed [7:0] data;
        logic              busy;
        logic              flag;
        logic              en;
        logic [4:0]        addr;
    } vec_t;

    vec_t vecs [28];

    // One full 20-tap load from IDLE; cycle 0 is the request cycle.
    task automatic apply_table(input string tag, input bit extra);
        for (int i = 0; i < 28; i++) begin
            req20 = vecs[i].req && (extra || i == 0);
            @(negedge clock);
            check($sformatf("%s_valid_%0d", tag, i), valid20, vecs[i].valid);
            check($sformatf("%s_data_%0d", tag, i), out20, vecs[i].data);
            check($sformatf("%s_busy_%0d", tag, i), busy20, vecs[i].busy);
            check($sformatf("%s_flag_%0d", tag, i), flag20, vecs[i].flag);
            check($sformatf("%s_en_%0d", tag, i), en20, vecs[i].en);
            check($sformatf("%s_addr_%0d", tag, i), addr20, vecs[i].addr);
            if (i == 8) check($sformatf("%s_neg77_hex", tag), {24'b0, out20}, 32'h0000_00B3);
            @(posedge clock);
            #1;
        end
        req20 = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 20; k++) store20[k] = 8'(coeffs20[k]);
        store1[0] = -8'sd128;
        store1[1] = 8'sd0;
        for (int k = 0; k < 16; k++) store16[k] = 8'(k * 9 - 60);

        for (int i = 0; i < 28; i++) begin
            vecs[i].req   = (i == 0) || (i == 5) || (i == 23);
            vecs[i].valid = (i >= 3) && (i <= 22);
            vecs[i].data  = (i < 3) ? 8'sd0 : ((i <= 22) ? store20[i-3] : store20[19]);
            vecs[i].busy  = (i >= 1) && (i <= 22);
            vecs[i].flag  = (i == 23);
            vecs[i].en    = (i >= 23);
            vecs[i].addr  = ((i >= 1) && (i <= 20)) ? 5'(i - 1) : 5'd0;
        end

        // Asynchronous reset mid-cycle: outputs clear before any clock edge
        #2 resetN = 1'b0;
        #1;
        check("rst_addr", addr20, 0);
        check("rst_out", out20, 0);
        check("rst_valid", valid20, 0);
        check("rst_busy", busy20, 0);
        check("rst_flag", flag20, 0);
        check("rst_en", en20, 0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        resetN = 1'b1;

        // Idle with no request: stays in IDLE
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("idle_en_%0d", i), en20, 0);
            check($sformatf("idle_busy_%0d", i), busy20, 0);
            check($sformatf("idle_valid_%0d", i), valid20, 0);
            check($sformatf("idle_addr_%0d", i), addr20, 0);
        end
        @(posedge clock); #1;

        // Single load with extra requests at n+5 and n+23 that must be ignored
        apply_table("load", 1'b1);

        // Reload from RUN with loadRequest held high: period of 24 cycles
        req20 = 1'b1;
        @(negedge clock);
        check("hold_en_run", en20, 1);
        check("hold_busy_run", busy20, 0);
        @(posedge clock); #1;
        vcount = 0;
        fcount = 0;
        for (int o = 1; o <= 71; o++) begin
            ph = o % 24;
            @(negedge clock);
            check($sformatf("hold_valid_%0d", o), valid20, (ph >= 3) && (ph <= 22));
            if ((ph >= 3) && (ph <= 22))
                check($sformatf("hold_data_%0d", o), out20, store20[ph-3]);
            check($sformatf("hold_flag_%0d", o), flag20, ph == 23);
            check($sformatf("hold_en_%0d", o), en20, (ph == 23) || (ph == 0));
            check($sformatf("hold_busy_%0d", o), busy20, (ph >= 1) && (ph <= 22));
            if (valid20) vcount++;
            if (flag20) fcount++;
            @(posedge clock); #1;
        end
        req20 = 1'b0;
        check("hold_valid_count", vcount, 60);
        check("hold_flag_count", fcount, 3);

        // Reset at the 10th valid strobe of a load started from RUN
        vcount = 0;
        for (int o = 0; o < 12; o++) begin
            req20 = (o == 0);
            @(negedge clock);
            if (valid20) vcount++;
            @(posedge clock); #1;
        end
        req20 = 1'b0;
        @(negedge clock);
        if (valid20) vcount++;
        check("mid_valid_10th", valid20, 1);
        check("mid_valid_count", vcount, 10);
        check("mid_data_10th", out20, store20[9]);
        resetN = 1'b0;
        #1;
        check("mid_rst_addr", addr20, 0);
        check("mid_rst_out", out20, 0);
        check("mid_rst_valid", valid20, 0);
        check("mid_rst_busy", busy20, 0);
        check("mid_rst_flag", flag20, 0);
        check("mid_rst_en", en20, 0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        resetN = 1'b1;
        vcount = 0;
        fcount = 0;
        for (int o = 0; o < 30; o++) begin
            @(negedge clock);
            if (valid20) vcount++;
            if (flag20) fcount++;
            @(posedge clock); #1;
        end
        check("post_rst_valid_count", vcount, 0);
        check("post_rst_flag_count", fcount, 0);
        check("post_rst_en", en20, 0);
        check("post_rst_busy", busy20, 0);

        // Full reload after reset starts again from address 0
        apply_table("reload", 1'b0);

        // LENGTH=1: single valid cycle at n+3 carrying -128, flag at n+4
        for (int o = 0; o < 7; o++) begin
            req1 = (o == 0);
            @(negedge clock);
            check($sformatf("l1_valid_%0d", o), valid1, o == 3);
            if (o == 3) check("l1_data", out1, -128);
            check($sformatf("l1_flag_%0d", o), flag1, o == 4);
            check($sformatf("l1_busy_%0d", o), busy1, (o >= 1) && (o <= 3));
            check($sformatf("l1_en_%0d", o), en1, o >= 4);
            check($sformatf("l1_addr_%0d", o), addr1, 0);
            @(posedge clock); #1;
        end
        req1 = 1'b0;

        // LENGTH=16: address walks 0..15 and returns to 0 without overrun
        for (int o = 0; o < 23; o++) begin
            req16 = (o == 0);
            @(negedge clock);
            check($sformatf("l16_addr_%0d", o), addr16, ((o >= 1) && (o <= 16)) ? o - 1 : 0);
            check($sformatf("l16_valid_%0d", o), valid16, (o >= 3) && (o <= 18));
            if ((o >= 3) && (o <= 18))
                check($sformatf("l16_data_%0d", o), out16, store16[o-3]);
            check($sformatf("l16_flag_%0d", o), flag16, o == 19);
            check($sformatf("l16_en_%0d", o), en16, o >= 19);
            @(posedge clock); #1;
        end
        req16 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
